tmds_channel_decoder: RTL and testbench

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

---
 rtl/tmds_channel_decoder_pkg.sv | 18 +
 rtl/tmds_channel_decoder_symbol_decode.sv | 18 +
 rtl/tmds_channel_decoder.sv | 160 ++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tmds_channel_decoder_pkg.sv
// Shared definitions for the TMDS channel decoder: control-token codes, FSM encoding and
// bit-slip offset width.
package tmds_channel_decoder_pkg;

  localparam int unsigned OffsetW = 4;

  // Control tokens, MSB-first notation (bit 0 is first on the wire).
  localparam logic [9:0] TokC00 = 10'b1101010100;
  localparam logic [9:0] TokC01 = 10'b0010101011;
  localparam logic [9:0] TokC10 = 10'b0101010100;
  localparam logic [9:0] TokC11 = 10'b1010101011;

  typedef enum logic [0:0] {
    StSearch,
    StLocked
  } state_e;

endpackage

// File: rtl/tmds_channel_decoder_symbol_decode.sv
// Combinational TMDS 10b->8b data decode (transition-minimised word to pixel byte).
module tmds_symbol_decode (
  input  logic [9:0] sym_i,
  output logic [7:0] data_o
);

  logic [7:0] q;

  always_comb begin
    q         = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data_o    = '0;
    data_o[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = sym_i[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: word alignment by bit-slip search on control tokens, then decode.
// Optional lock-loss counter port enabled by defining TMDS_DECODER_STATS_EN.
module tmds_channel_decoder
  import tmds_channel_decoder_pkg::*;
#(
  parameter int unsigned C_lock_count   = 16,
  parameter int unsigned C_search_bits  = 12,
  parameter int unsigned C_timeout_bits = 20
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic [9:0]         in_raw,
  output logic [7:0]         out_data,
  output logic               out_de,
  output logic [1:0]         out_c,
  output logic               out_locked,
  output logic [OffsetW-1:0] out_offset
`ifdef TMDS_DECODER_STATS_EN
  ,
  output logic [15:0]        out_lock_losses
`endif
);

  localparam int unsigned TimerW = (C_search_bits > C_timeout_bits) ? C_search_bits
                                                                    : C_timeout_bits;
  localparam int unsigned RunW = $clog2(C_lock_count + 1);
  localparam logic [TimerW-1:0] DwellTc   = {TimerW{1'b1}} >> (TimerW - C_search_bits);
  localparam logic [TimerW-1:0] TimeoutTc = {TimerW{1'b1}} >> (TimerW - C_timeout_bits);
  localparam logic [RunW-1:0]   LockRun   = RunW'(C_lock_count - 1);

  state_e               state_q;
  logic [OffsetW-1:0]   offset_q;
  logic [RunW-1:0]      run_q;
  logic [TimerW-1:0]    timer_q;
  logic [9:0]           prev_q, sym_q;
  logic                 tok_q;
  logic [1:0]           code_q;
  logic [7:0]           out_data_q;
  logic                 out_de_q;
  logic [1:0]           out_c_q;

  logic [19:0]          shifted;
  logic [9:0]           sym;
  logic                 tok;
  logic [1:0]           code;
  logic [7:0]           dec_data;
  logic [OffsetW-1:0]   next_offset;
  logic                 lock_evt, drop_evt, locked_next;

  assign shifted = {in_raw, prev_q} >> offset_q;
  assign sym     = shifted[9:0];

  always_comb begin
    tok  = 1'b1;
    code = 2'b00;
    case (sym)
      TokC00:  code = 2'b00;
      TokC01:  code = 2'b01;
      TokC10:  code = 2'b10;
      TokC11:  code = 2'b11;
      default: tok  = 1'b0;
    endcase
  end

  tmds_symbol_decode u_decode (
    .sym_i  (sym_q),
    .data_o (dec_data)
  );

  assign next_offset = (offset_q == OffsetW'(9)) ? '0 : offset_q + 1'b1;
  assign lock_evt    = (state_q == StSearch) && tok_q && (run_q == LockRun);
  assign drop_evt    = (state_q == StLocked) && !tok_q && (timer_q == TimeoutTc);
  // Output gating follows the state being entered so out_locked and the data path agree.
  assign locked_next = lock_evt || ((state_q == StLocked) && !drop_evt);

`ifdef TMDS_DECODER_STATS_EN
  logic [15:0] losses_q;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      losses_q <= '0;
    end else if (drop_evt && (losses_q != 16'hFFFF)) begin
      losses_q <= losses_q + 1'b1;
    end
  end

  assign out_lock_losses = losses_q;
`endif

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q    <= StSearch;
      offset_q   <= '0;
      run_q      <= '0;
      timer_q    <= '0;
      prev_q     <= '0;
      sym_q      <= '0;
      tok_q      <= 1'b0;
      code_q     <= 2'b00;
      out_data_q <= '0;
      out_de_q   <= 1'b0;
      out_c_q    <= 2'b00;
    end else begin
      prev_q <= in_raw;
      sym_q  <= sym;
      tok_q  <= tok;
      code_q <= code;

      if (!locked_next) begin
        out_de_q   <= 1'b0;
        out_c_q    <= 2'b00;
        out_data_q <= '0;
      end else if (tok_q) begin
        out_de_q   <= 1'b0;
        out_c_q    <= code_q;
        out_data_q <= '0;
      end else begin
        out_de_q   <= 1'b1;
        out_data_q <= dec_data;
      end

      unique case (state_q)
        StSearch: begin
          if (lock_evt) begin
            state_q <= StLocked;
            run_q   <= '0;
            timer_q <= '0;
          end else if (timer_q == DwellTc) begin
            offset_q <= next_offset;
            run_q    <= '0;
            timer_q  <= '0;
          end else begin
            run_q   <= tok_q ? run_q + 1'b1 : '0;
            timer_q <= timer_q + 1'b1;
          end
        end
        StLocked: begin
          if (tok_q) begin
            timer_q <= '0;
          end else if (drop_evt) begin
            state_q  <= StSearch;
            offset_q <= next_offset;
            run_q    <= '0;
            timer_q  <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_de     = out_de_q;
  assign out_c      = out_c_q;
  assign out_locked = (state_q == StLocked);
  assign out_offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder with shortened dwell (64) and timeout (256) periods.
module tb_tmds_channel_decoder;

  localparam logic [9:0] T0  = 10'b1101010100;
  localparam logic [9:0] T1  = 10'b0010101011;
  localparam logic [9:0] T2  = 10'b0101010100;
  localparam logic [9:0] T3  = 10'b1010101011;
  localparam logic [9:0] DA5 = 10'h163;  // decodes to 8'hA5 (xor path, no inversion)
  localparam logic [9:0] D3C = 10'h241;  // decodes to 8'h3C (xnor path, inverted)

  logic       clk_pixel = 1'b0;
  logic       reset     = 1'b1;
  logic [9:0] in_raw    = '0;
  logic [7:0] out_data;
  logic       out_de;
  logic [1:0] out_c;
  logic       out_locked;
  logic [3:0] out_offset;
`ifdef TMDS_DECODER_STATS_EN
  logic [15:0] out_lock_losses;
`endif

  int         n_vec   = 0;
  int         n_err   = 0;
  int         p_shift = 0;
  logic [9:0] sym_prev = '0;

  always #5 clk_pixel = ~clk_pixel;

  tmds_channel_decoder #(
    .C_lock_count   (16),
    .C_search_bits  (6),
    .C_timeout_bits (8)
  ) dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .in_raw     (in_raw),
    .out_data   (out_data),
    .out_de     (out_de),
    .out_c      (out_c),
    .out_locked (out_locked),
    .out_offset (out_offset)
`ifdef TMDS_DECODER_STATS_EN
    ,
    .out_lock_losses (out_lock_losses)
`endif
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Serialise symbols with a p_shift-bit lead-in so alignment lands at offset p_shift.
  task automatic send(input logic [9:0] s);
    logic [19:0] pair;
    pair     = {s, sym_prev} >> (10 - p_shift);
    in_raw   = pair[9:0];
    sym_prev = s;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    sym_prev = '0;
    in_raw   = '0;
    @(posedge clk_pixel);
    #1;
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [9:0] pat(input int i);
    return ((i % 80) < 50) ? T0 : DA5;
  endfunction

  initial begin
    logic [9:0] toks [4];
    int         guard;
    toks = '{T1, T2, T3, T0};

    // Reset state
    do_reset();
    check_eq("rst_locked", 16'(out_locked), 16'd0);
    check_eq("rst_offset", 16'(out_offset), 16'd0);
    check_eq("rst_de", 16'(out_de), 16'd0);
    check_eq("rst_c", 16'(out_c), 16'd0);
    check_eq("rst_data", 16'(out_data), 16'd0);
`ifdef TMDS_DECODER_STATS_EN
    check_eq("rst_losses", out_lock_losses, 16'd0);
`endif

    // Aligned lock: locked exactly two edges after the 16th token word
    for (int k = 1; k <= 20; k++) begin
      send(T0);
      if (k == 17) check_eq("lock_early", 16'(out_locked), 16'd0);
      if (k == 18) begin
        check_eq("lock_16th", 16'(out_locked), 16'd1);
        check_eq("lock_de", 16'(out_de), 16'd0);
      end
    end
    send(DA5);
    send(DA5);
    check_eq("a5_lat2_de", 16'(out_de), 16'd0);
    send(DA5);
    check_eq("a5_lat3_de", 16'(out_de), 16'd1);
    check_eq("a5_data", 16'(out_data), 16'h00A5);
    check_eq("a5_c", 16'(out_c), 16'd0);
    send(D3C);
    send(DA5);
    send(DA5);
    check_eq("3c_data", 16'(out_data), 16'h003C);
    check_eq("3c_de", 16'(out_de), 16'd1);

    // Each control token while locked, then out_c holds through data
    for (int t = 0; t < 4; t++) begin
      send(toks[t]);
      send(DA5);
      send(DA5);
      check_eq("tok_de", 16'(out_de), 16'd0);
      check_eq("tok_c", 16'(out_c), 16'((t + 1) % 4));
      check_eq("tok_data", 16'(out_data), 16'd0);
      send(DA5);
      check_eq("tok_hold_de", 16'(out_de), 16'd1);
      check_eq("tok_hold_c", 16'(out_c), 16'((t + 1) % 4));
    end

    // Reset mid-lock
    reset = 1'b1;
    send(DA5);
    check_eq("mid_rst_locked", 16'(out_locked), 16'd0);
    check_eq("mid_rst_offset", 16'(out_offset), 16'd0);
    check_eq("mid_rst_de", 16'(out_de), 16'd0);
`ifdef TMDS_DECODER_STATS_EN
    check_eq("mid_rst_losses", out_lock_losses, 16'd0);
`endif
    reset = 1'b0;

    // Relock, then timeout: drop after 258 data words following the last token
    for (int k = 0; k < 20; k++) send(T0);
    check_eq("relock", 16'(out_locked), 16'd1);
    for (int d = 0; d < 257; d++) send(DA5);
    check_eq("to_still_locked", 16'(out_locked), 16'd1);
    send(DA5);
    check_eq("to_dropped", 16'(out_locked), 16'd0);
    check_eq("to_offset", 16'(out_offset), 16'd1);
    check_eq("to_de", 16'(out_de), 16'd0);
`ifdef TMDS_DECODER_STATS_EN
    check_eq("to_losses", out_lock_losses, 16'd1);
`endif

    // 16th token lands on the dwell terminal-count edge: lock wins, offset unchanged
    do_reset();
    for (int k = 0; k < 46; k++) send(DA5);
    for (int k = 0; k < 16; k++) send(T0);
    send(T0);
    check_eq("tc_pre_locked", 16'(out_locked), 16'd0);
    check_eq("tc_pre_offset", 16'(out_offset), 16'd0);
    send(T0);
    check_eq("tc_locked", 16'(out_locked), 16'd1);
    check_eq("tc_offset", 16'(out_offset), 16'd0);

    // Stream shifted by 7 bits: offset steps every 64 words, then locks at 7
    p_shift = 7;
    do_reset();
    for (int i = 0; i < 448; i++) begin
      send(pat(i));
      if (((i + 1) % 64) == 32) begin
        check_eq("srch_offset", 16'(out_offset), 16'((i + 1) / 64));
        check_eq("srch_de", 16'(out_de), 16'd0);
        check_eq("srch_data", 16'(out_data), 16'd0);
      end
    end
    guard = 448;
    while (!out_locked && guard < 1300) begin
      send(pat(guard));
      guard++;
    end
    check_eq("shift_locked", 16'(out_locked), 16'd1);
    check_eq("shift_offset", 16'(out_offset), 16'd7);
    while (!out_de && guard < 1400) begin
      send(pat(guard));
      guard++;
    end
    check_eq("shift_de", 16'(out_de), 16'd1);
    check_eq("shift_data", 16'(out_data), 16'h00A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
